// File: rtl/xps2_rx_pkg.sv
// xps2_rx shared definitions: register offsets, STATUS/CTRL bit positions,
// receiver FSM state encoding and the FIFO count width helper.
package xps2_rx_pkg;

   // Register offsets (word index on data_addr)
   localparam logic [1:0] XPS2_DATA   = 2'd0;
   localparam logic [1:0] XPS2_STATUS = 2'd1;
   localparam logic [1:0] XPS2_CTRL   = 2'd2;
   localparam logic [1:0] XPS2_FLUSH  = 2'd3;

   // DATA register fields
   localparam int DATA_VLD_BIT = 8;

   // STATUS register bit indices
   localparam int STAT_NE      = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVR     = 2;
   localparam int STAT_PERR    = 3;
   localparam int STAT_FERR    = 4;
   localparam int STAT_CNT_LSB = 8;

   // CTRL register bit indices
   localparam int CTRL_EN  = 0;
   localparam int CTRL_IRQ = 1;

   // Receiver FSM states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } xps2_state_t;

   // FIFO occupancy width: must hold the value DEPTH itself
   function automatic int xps2_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/xps2_rx_xfifo.sv
// Generic synchronous FIFO with push / pop / flush, full / empty / count and
// a combinational head output (0 when empty). A pop on empty is ignored; a
// push on full is accepted only if a pop happens in the same cycle. Flush
// wins over a simultaneous push or pop.
module xps2_rx_xfifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, written only on an accepted push (no reset needed)
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/xps2_rx.sv
// xps2_rx: memory-mapped PS/2 keyboard receiver. Synchronises the PS/2 pins,
// deserialises 11-bit frames on ps2_clk falling edges, checks odd parity and
// the stop bit, and queues good scancodes in a FIFO polled through DATA,
// STATUS, CTRL and FLUSH registers.
// Optional build macro XPS2_IRQ_EN adds a registered irq output and a stored
// CTRL.irq_en bit; without it CTRL bit1 reads 0 and there is no irq port.
module xps2_rx
   import xps2_rx_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   input  logic              data_sel,
   input  logic              data_we,
   input  logic [1:0]        data_addr,
   input  logic [DATA_W-1:0] data_to_wr,
   output logic [DATA_W-1:0] data_to_rd
`ifdef XPS2_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int            CW       = xps2_cnt_w(FIFO_DEPTH);
   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("xps2_rx: FIFO_DEPTH must be a power of two and at least 2");
   end

   // Pin synchronisers and edge history
   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q;
   logic fall;

   // Receiver state
   xps2_state_t   state_q;
   logic [2:0]    bit_cnt_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    shreg_q;
   logic          par_q;
   logic          tmo_hit;
   logic          stop_seen, frame_ok;
   logic          frame_push, perr_set, ferr_set, ovr_set;

   // Control / status registers
   logic enable_q;
   logic ovr_q, perr_q, ferr_q;
`ifdef XPS2_IRQ_EN
   logic irq_en_q;
   logic irq_q;
`endif

   // Bus decode
   logic wr_status, wr_ctrl, wr_flush, rd_pop;

   // FIFO interface
   logic [7:0]    fifo_head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   logic unused_wr_bits;
   assign unused_wr_bits = ^{data_to_wr[DATA_W-1:5], data_to_wr[1]};

   assign wr_status = data_sel & data_we  & (data_addr == XPS2_STATUS);
   assign wr_ctrl   = data_sel & data_we  & (data_addr == XPS2_CTRL);
   assign wr_flush  = data_sel & data_we  & (data_addr == XPS2_FLUSH);
   assign rd_pop    = data_sel & ~data_we & (data_addr == XPS2_DATA);

   // Two-flop synchronisers; idle-high reset so reset never manufactures a fall
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign fall = clk_prev_q & ~clk_s2_q;

   // Frame completion and error strobes, evaluated in the cycle the stop bit falls
   assign stop_seen  = (state_q == S_STOP) & fall;
   assign frame_ok   = ^{shreg_q, par_q};
   assign tmo_hit    = (state_q != S_IDLE) & ~fall & (tmo_q == TMO_LAST);
   assign frame_push = stop_seen & dat_s2_q & frame_ok;
   assign perr_set   = stop_seen & dat_s2_q & ~frame_ok;
   assign ferr_set   = (stop_seen & ~dat_s2_q) | tmo_hit;
   assign ovr_set    = frame_push & fifo_full & ~rd_pop & ~wr_flush;

   // Receiver FSM with bit counter and mid-frame inactivity timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         tmo_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fall && !dat_s2_q && enable_q) begin
                  state_q   <= S_DATA;
                  bit_cnt_q <= '0;
               end
            end
            S_DATA: begin
               if (fall) begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (fall) state_q <= S_STOP;
            end
            S_STOP: begin
               if (fall) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         if ((state_q == S_IDLE) || fall) begin
            tmo_q <= '0;
         end else if (tmo_hit) begin
            tmo_q   <= '0;
            state_q <= S_IDLE;
         end else begin
            tmo_q <= tmo_q + 1'b1;
         end
      end
   end

   // Data shift register (LSB first) and captured parity bit
   always_ff @(posedge clk) begin
      if (fall && (state_q == S_DATA))   shreg_q <= {dat_s2_q, shreg_q[7:1]};
      if (fall && (state_q == S_PARITY)) par_q   <= dat_s2_q;
   end

   // Sticky error flags: a set in the same cycle as a W1C clear wins
   always_ff @(posedge clk) begin
      if (rst) begin
         ovr_q  <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovr_q  <= ovr_set  | (ovr_q  & ~(wr_status & data_to_wr[STAT_OVR]));
         perr_q <= perr_set | (perr_q & ~(wr_status & data_to_wr[STAT_PERR]));
         ferr_q <= ferr_set | (ferr_q & ~(wr_status & data_to_wr[STAT_FERR]));
      end
   end

   // CTRL register
   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q <= 1'b1;
`ifdef XPS2_IRQ_EN
         irq_en_q <= 1'b0;
`endif
      end else if (wr_ctrl) begin
         enable_q <= data_to_wr[CTRL_EN];
`ifdef XPS2_IRQ_EN
         irq_en_q <= data_to_wr[CTRL_IRQ];
`endif
      end
   end

`ifdef XPS2_IRQ_EN
   // Registered interrupt: follows the enabled condition one clk later
   always_ff @(posedge clk) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_en_q & (~fifo_empty | ovr_q | perr_q | ferr_q);
   end

   assign irq = irq_q;
`endif

   xps2_rx_xfifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (frame_push),
      .pop_i   (rd_pop),
      .flush_i (wr_flush),
      .wdata_i (shreg_q),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Combinational read mux; zero whenever the block is not selected
   always_comb begin
      data_to_rd = '0;
      if (data_sel) begin
         case (data_addr)
            XPS2_DATA: begin
               data_to_rd[7:0]          = fifo_head;
               data_to_rd[DATA_VLD_BIT] = ~fifo_empty;
            end
            XPS2_STATUS: begin
               data_to_rd[STAT_NE]                      = ~fifo_empty;
               data_to_rd[STAT_FULL]                    = fifo_full;
               data_to_rd[STAT_OVR]                     = ovr_q;
               data_to_rd[STAT_PERR]                    = perr_q;
               data_to_rd[STAT_FERR]                    = ferr_q;
               data_to_rd[STAT_CNT_LSB+7:STAT_CNT_LSB]  = 8'(fifo_count);
            end
            XPS2_CTRL: begin
               data_to_rd[CTRL_EN] = enable_q;
`ifdef XPS2_IRQ_EN
               data_to_rd[CTRL_IRQ] = irq_en_q;
`else
               data_to_rd[CTRL_IRQ] = 1'b0;
`endif
            end
            default: data_to_rd = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_xps2_rx.sv
// Testbench for xps2_rx: directed scenarios plus randomized frames and
// register accesses checked against a queue-based reference model.
module tb_xps2_rx;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int TMO    = 300;

   logic              clk = 1'b0;
   logic              rst;
   logic              ps2_clk;
   logic              ps2_data;
   logic              data_sel;
   logic              data_we;
   logic [1:0]        data_addr;
   logic [DATA_W-1:0] data_to_wr;
   logic [DATA_W-1:0] data_to_rd;
`ifdef XPS2_IRQ_EN
   logic              irq;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   byte unsigned mq[$];
   bit           m_ovr, m_perr, m_ferr;
   bit           m_en;

   always #5 clk = ~clk;

   xps2_rx #(
      .DATA_W         (DATA_W),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .data_sel   (data_sel),
      .data_we    (data_we),
      .data_addr  (data_addr),
      .data_to_wr (data_to_wr),
      .data_to_rd (data_to_rd)
`ifdef XPS2_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void m_reset();
      mq.delete();
      m_ovr  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_en   = 1'b1;
   endfunction

   function automatic logic [31:0] m_status();
      return {16'd0, 8'(mq.size()), 3'd0, m_ferr, m_perr, m_ovr,
              (mq.size() == DEPTH), (mq.size() != 0)};
   endfunction

   function automatic logic [31:0] m_pop();
      if (mq.size() == 0) return 32'd0;
      return {23'd0, 1'b1, mq.pop_front()};
   endfunction

   function automatic void m_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      if (!m_en) return;
      if (bad_stop)                m_ferr = 1'b1;
      else if (bad_par)            m_perr = 1'b1;
      else if (mq.size() < DEPTH)  mq.push_back(d);
      else                         m_ovr = 1'b1;
   endfunction

   // ---------------- bus access ----------------
   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      data_sel  = 1'b1;
      data_we   = 1'b0;
      data_addr = a;
      #1 d = data_to_rd;
      @(negedge clk);
      data_sel  = 1'b0;
   endtask

   // Read with check; expected value for DATA comes from the caller
   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] got;
      bus_rd(a, got);
      if (a == 2'd0) void'(m_pop());
      chk(tag, got, exp);
   endtask

   task automatic data_chk(input string tag);
      logic [31:0] exp;
      logic [31:0] got;
      exp = m_pop();
      bus_rd(2'd0, got);
      chk(tag, got, exp);
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      data_sel   = 1'b1;
      data_we    = 1'b1;
      data_addr  = a;
      data_to_wr = d;
      @(negedge clk);
      data_sel   = 1'b0;
      data_we    = 1'b0;
      case (a)
         2'd1: begin
            if (d[2]) m_ovr  = 1'b0;
            if (d[3]) m_perr = 1'b0;
            if (d[4]) m_ferr = 1'b0;
         end
         2'd2: m_en = d[0];
         2'd3: mq.delete();
         default: ;
      endcase
   endtask

   // ---------------- PS/2 device side ----------------
   // One bit cell: data set up, clock low 6 clk, clock high. Optionally a DATA
   // read is placed on the clk edge where the falling edge is processed.
   task automatic ps2_bit(input logic b, input bit pop, output logic [31:0] rd);
      rd = 32'd0;
      @(negedge clk);
      ps2_data = b;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop) begin
         repeat (2) @(negedge clk);
         data_sel  = 1'b1;
         data_we   = 1'b0;
         data_addr = 2'd0;
         #1 rd = data_to_rd;
         @(negedge clk);
         data_sel  = 1'b0;
         repeat (3) @(negedge clk);
      end else begin
         repeat (6) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                       input bit pop_at_stop, output logic [31:0] rd);
      logic [10:0] bits;
      logic [31:0] junk;
      bits = {~bad_stop, ~(^d) ^ bad_par, d, 1'b0};
      rd = 32'd0;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) ps2_bit(bits[i], pop_at_stop, rd);
         else         ps2_bit(bits[i], 1'b0, junk);
      end
      ps2_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic fr(input logic [7:0] d, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
      logic [31:0] junk;
      send(d, bad_par, bad_stop, 1'b0, junk);
      m_frame(d, bad_par, bad_stop);
   endtask

   task automatic partial(input logic [7:0] d, input int ndata);
      logic [31:0] junk;
      ps2_bit(1'b0, 1'b0, junk);
      for (int i = 0; i < ndata; i++) ps2_bit(d[i], 1'b0, junk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] rd;
      int          r;
      logic [7:0]  d;
      bit          bp, bs;
      logic [31:0] mask;

      rst        = 1'b1;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      data_sel   = 1'b0;
      data_we    = 1'b0;
      data_addr  = 2'd0;
      data_to_wr = '0;
      do_reset();

      // Reset state
      rd_chk("rst_status", 2'd1, 32'h0000_0000);
      rd_chk("rst_ctrl",   2'd2, 32'h0000_0001);
      rd_chk("rst_data",   2'd0, 32'h0000_0000);
      rd_chk("rst_resv",   2'd3, 32'h0000_0000);

      // Good frame 0x1C
      fr(8'h1C);
      rd_chk("f1c_status", 2'd1, 32'h0000_0101);
      @(negedge clk);
      data_addr = 2'd1;
      #1 chk("unsel_zero", data_to_rd, 32'h0);
      rd_chk("f1c_data",   2'd0, 32'h0000_011C);
      rd_chk("f1c_after",  2'd1, 32'h0000_0000);

      // Bad parity
      fr(8'h1C, 1'b1, 1'b0);
      rd_chk("perr_status", 2'd1, 32'h0000_0008);
      rd_chk("perr_data",   2'd0, 32'h0000_0000);
      bus_wr(2'd1, 32'h08);
      rd_chk("perr_clr",    2'd1, 32'h0000_0000);

      // Bad stop bit
      fr(8'h77, 1'b0, 1'b1);
      rd_chk("ferr_stop", 2'd1, 32'h0000_0010);
      bus_wr(2'd1, 32'h10);

      // Overflow: nine frames, no reads
      for (int i = 1; i <= 9; i++) fr(8'(i));
      rd_chk("ovr_status", 2'd1, 32'h0000_0807);
      for (int i = 1; i <= 8; i++) rd_chk($sformatf("ovr_data%0d", i), 2'd0, 32'h100 + 32'(i));
      rd_chk("ovr_sticky", 2'd1, 32'h0000_0004);
      bus_wr(2'd1, 32'h04);
      rd_chk("ovr_clr",    2'd1, 32'h0000_0000);

      // Timeout mid-frame
      partial(8'hFF, 4);
      repeat (TMO + 2) @(negedge clk);
      m_ferr = 1'b1;
      rd_chk("tmo_status", 2'd1, 32'h0000_0010);
      bus_wr(2'd1, 32'h10);
      fr(8'h5A);
      rd_chk("tmo_next",   2'd0, 32'h0000_015A);

      // Reset mid-frame
      fr(8'h3C);
      partial(8'hA5, 5);
      do_reset();
      rd_chk("rstmid_status", 2'd1, 32'h0000_0000);
      rd_chk("rstmid_ctrl",   2'd2, 32'h0000_0001);
      fr(8'hF0);
      rd_chk("rstmid_next",   2'd0, 32'h0000_01F0);

      // Enable off blocks new frames; irq_en not stored in the default build
      bus_wr(2'd2, 32'h0);
      rd_chk("en_off_ctrl", 2'd2, 32'h0000_0000);
      fr(8'h42);
      rd_chk("en_off_stat", 2'd1, 32'h0000_0000);
      bus_wr(2'd2, 32'h3);
`ifdef XPS2_IRQ_EN
      rd_chk("en_on_ctrl",  2'd2, 32'h0000_0003);
`else
      rd_chk("en_on_ctrl",  2'd2, 32'h0000_0001);
`endif
      bus_wr(2'd2, 32'h1);

      // Full FIFO, pop coincides with push of 0x33
      for (int i = 0; i < 8; i++) fr(8'hA0 + 8'(i));
      rd_chk("coin_full", 2'd1, 32'h0000_0803);
      void'(m_pop());
      send(8'h33, 1'b0, 1'b0, 1'b1, rd);
      m_frame(8'h33, 1'b0, 1'b0);
      chk("coin_head", rd, 32'h0000_01A0);
      rd_chk("coin_status", 2'd1, 32'h0000_0803);
      for (int i = 1; i < 8; i++) rd_chk($sformatf("coin_data%0d", i), 2'd0, 32'h1A0 + 32'(i));
      rd_chk("coin_last", 2'd0, 32'h0000_0133);

      // Flush
      fr(8'h11);
      fr(8'h22);
      fr(8'h44);
      rd_chk("flush_pre",  2'd1, 32'h0000_0301);
      bus_wr(2'd3, 32'h0);
      rd_chk("flush_post", 2'd1, 32'h0000_0000);

      // Randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 99);
         if (r < 55) begin
            d  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 11) == 0);
            fr(d, bp, bs);
         end else if (r < 85) begin
            data_chk("rnd_data");
         end else if (r < 95) begin
            mask = 32'($urandom_range(0, 7)) << 2;
            bus_wr(2'd1, mask);
         end else begin
            bus_wr(2'd3, 32'h0);
         end
         bus_rd(2'd1, rd);
         chk("rnd_status", rd, m_status());
      end

      // Drain
      for (int k = 0; k < DEPTH + 1; k++) data_chk("drain_data");
      bus_rd(2'd1, rd);
      chk("drain_status", rd, m_status());

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
